// File: rtl/alu_issue_scheduler_pkg.sv
// Shared types for the ALU reservation-station scheduler.
// Payload widths here set the default data, ROB-tag and ALU-control widths.
// rs_entry_t is one scheduler slot: valid bit, control, destination and two operands.
package alu_issue_scheduler_pkg;

   localparam int RS_WIDTH = 31;   // MSB index of operand values
   localparam int RS_ROB   = 2;    // MSB index of ROB tags
   localparam int RS_ALUOP = 3;    // MSB index of ALU control

   typedef struct packed {
      logic                valid;
      logic [RS_ALUOP:0]   op;
      logic [RS_ROB:0]     rob;
      logic                rdy1;
      logic [RS_ROB:0]     tag1;
      logic [RS_WIDTH:0]   val1;
      logic                rdy2;
      logic [RS_ROB:0]     tag2;
      logic [RS_WIDTH:0]   val2;
   } rs_entry_t;

endpackage

// File: rtl/alu_issue_scheduler_cdb_if.sv
// Common data bus: one result broadcast per cycle, tagged with its ROB entry.
// Reservation stations only listen; the arbiter side drives it.
// No flow control: a broadcast is valid for exactly the cycle validBroadcast is high.
interface commonDataBus #(
   parameter int WIDTH = 31,
   parameter int ROB   = 2
);
   logic [WIDTH:0] result;
   logic [ROB:0]   robEntry;
   logic           validBroadcast;

   modport reservation_station (
      input result,
      input robEntry,
      input validBroadcast
   );

   modport arbiter (
      output result,
      output robEntry,
      output validBroadcast
   );
endinterface

// File: rtl/alu_issue_scheduler_age_matrix_select.sv
// Age matrix plus oldest-ready select for the scheduler slots.
// Grant is combinational from the current matrix; matrix updates at the clock edge.
// No backpressure of its own: the caller decides whether the grant is consumed.
module age_matrix_select #(
   parameter int ENTRIES = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic [ENTRIES-1:0] alloc,
   input  logic [ENTRIES-1:0] valid,
   input  logic [ENTRIES-1:0] ready,
   output logic [ENTRIES-1:0] grant,
   output logic               any
);

   // age[i][j] = 1 means slot i was dispatched before slot j
   logic [ENTRIES-1:0] age     [ENTRIES];
   logic [ENTRIES-1:0] age_nxt [ENTRIES];

   // A new slot is younger than everything currently valid: clear its row, set its column
   always_comb begin
      age_nxt = age;
      if (flush) begin
         for (int i = 0; i < ENTRIES; i++) begin
            age_nxt[i] = '0;
         end
      end else begin
         for (int k = 0; k < ENTRIES; k++) begin
            if (alloc[k]) begin
               age_nxt[k] = '0;
               for (int i = 0; i < ENTRIES; i++) begin
                  if (valid[i]) begin
                     age_nxt[i][k] = 1'b1;
                  end
               end
            end
         end
      end
   end

   // Matrix flops
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            age[i] <= '0;
         end
      end else begin
         age <= age_nxt;
      end
   end

   // A ready slot wins only if it is older than every other ready slot
   always_comb begin
      grant = ready;
      for (int i = 0; i < ENTRIES; i++) begin
         for (int j = 0; j < ENTRIES; j++) begin
            if ((j != i) && ready[j] && !age[i][j]) begin
               grant[i] = 1'b0;
            end
         end
      end
      any = |ready;
   end

endmodule

// File: rtl/alu_issue_scheduler.sv
// ALU reservation station: holds dispatched ops, wakes operands off the CDB, issues oldest ready.
// Latency: ready-at-dispatch op issues one edge after dispatch; woken op one edge after the broadcast.
// Backpressure: dispReady drops when all slots are full; issue stalls (registers hold) while fuAvailable=0.
module alu_issue_scheduler
   import alu_issue_scheduler_pkg::*;
#(
   parameter int WIDTH   = RS_WIDTH,
   parameter int ROB     = RS_ROB,
   parameter int ALUOP   = RS_ALUOP,
   parameter int ENTRIES = 4
) (
   input  logic                        clk,
   input  logic                        globalReset,
   input  logic                        clear,
   input  logic                        validCommit,
   commonDataBus.reservation_station   dataBus,
   input  logic                        dispValid,
   output logic                        dispReady,
   input  logic [ALUOP:0]              dispOp,
   input  logic [ROB:0]                dispRob,
   input  logic                        dispRdy1,
   input  logic                        dispRdy2,
   input  logic [ROB:0]                dispTag1,
   input  logic [ROB:0]                dispTag2,
   input  logic [WIDTH:0]              dispVal1,
   input  logic [WIDTH:0]              dispVal2,
   input  logic                        fuAvailable,
   output logic                        issueValid,
   output logic [ALUOP:0]              issueOp,
   output logic [ROB:0]                issueRob,
   output logic [WIDTH:0]              issueOp1,
   output logic [WIDTH:0]              issueOp2,
   output logic [$clog2(ENTRIES):0]    occupancy
);

   localparam int OCC_W = $clog2(ENTRIES) + 1;

   rs_entry_t          slots     [ENTRIES];
   rs_entry_t          slots_nxt [ENTRIES];
   rs_entry_t          new_entry;
   rs_entry_t          winner;

   logic               flush;
   logic               issue_fire;
   logic               any_ready;
   logic [ENTRIES-1:0] valid_vec;
   logic [ENTRIES-1:0] ready_vec;
   logic [ENTRIES-1:0] free_vec;
   logic [ENTRIES-1:0] free_lowest;
   logic [ENTRIES-1:0] alloc;
   logic [ENTRIES-1:0] grant;
   logic [OCC_W-1:0]   occ_nxt;

   assign flush = clear & validCommit;

   // Slot status vectors and lowest-index free slot
   always_comb begin
      for (int i = 0; i < ENTRIES; i++) begin
         valid_vec[i] = slots[i].valid;
         ready_vec[i] = slots[i].valid & slots[i].rdy1 & slots[i].rdy2;
      end
      free_vec    = ~valid_vec;
      free_lowest = free_vec & (~free_vec + {{(ENTRIES-1){1'b0}}, 1'b1});
   end

   // Free space is judged from current state only; a slot issuing this cycle is not reusable yet
   assign dispReady  = |free_vec;
   assign alloc      = (dispValid && dispReady && !flush) ? free_lowest : '0;
   assign issue_fire = fuAvailable & any_ready & ~flush;

   age_matrix_select #(
      .ENTRIES (ENTRIES)
   ) u_age (
      .clk   (clk),
      .rst   (globalReset),
      .flush (flush),
      .alloc (alloc),
      .valid (valid_vec),
      .ready (ready_vec),
      .grant (grant),
      .any   (any_ready)
   );

   // Incoming op, capturing a same-cycle broadcast for operands that are still pending
   always_comb begin
      new_entry       = '0;
      new_entry.valid = 1'b1;
      new_entry.op    = dispOp;
      new_entry.rob   = dispRob;
      new_entry.tag1  = dispTag1;
      new_entry.tag2  = dispTag2;
      new_entry.rdy1  = dispRdy1;
      new_entry.val1  = dispVal1;
      new_entry.rdy2  = dispRdy2;
      new_entry.val2  = dispVal2;
      if (!dispRdy1 && dataBus.validBroadcast && (dataBus.robEntry == dispTag1)) begin
         new_entry.rdy1 = 1'b1;
         new_entry.val1 = dataBus.result;
      end
      if (!dispRdy2 && dataBus.validBroadcast && (dataBus.robEntry == dispTag2)) begin
         new_entry.rdy2 = 1'b1;
         new_entry.val2 = dataBus.result;
      end
   end

   // Next slot state: flush wins; otherwise wakeup, issue-free and dispatch on disjoint slots
   always_comb begin
      slots_nxt = slots;
      if (flush) begin
         for (int i = 0; i < ENTRIES; i++) begin
            slots_nxt[i].valid = 1'b0;
         end
      end else begin
         for (int i = 0; i < ENTRIES; i++) begin
            if (slots[i].valid) begin
               if (!slots[i].rdy1 && dataBus.validBroadcast && (dataBus.robEntry == slots[i].tag1)) begin
                  slots_nxt[i].rdy1 = 1'b1;
                  slots_nxt[i].val1 = dataBus.result;
               end
               if (!slots[i].rdy2 && dataBus.validBroadcast && (dataBus.robEntry == slots[i].tag2)) begin
                  slots_nxt[i].rdy2 = 1'b1;
                  slots_nxt[i].val2 = dataBus.result;
               end
               if (issue_fire && grant[i]) begin
                  slots_nxt[i].valid = 1'b0;
               end
            end
            if (alloc[i]) begin
               slots_nxt[i] = new_entry;
            end
         end
      end
   end

   // Slot storage
   always_ff @(posedge clk or posedge globalReset) begin
      if (globalReset) begin
         for (int i = 0; i < ENTRIES; i++) begin
            slots[i] <= '0;
         end
      end else begin
         slots <= slots_nxt;
      end
   end

   // Occupancy tracks the valid bits that will be present after this edge
   always_comb begin
      occ_nxt = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         occ_nxt = occ_nxt + OCC_W'(slots_nxt[i].valid);
      end
   end

   // Occupancy register
   always_ff @(posedge clk or posedge globalReset) begin
      if (globalReset) begin
         occupancy <= '0;
      end else begin
         occupancy <= occ_nxt;
      end
   end

   // One-hot grant mux; all-zero when nothing is ready
   always_comb begin
      winner = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         if (grant[i]) begin
            winner = slots[i];
         end
      end
   end

   // Issue registers: load whenever the ALU can accept, hold otherwise
   always_ff @(posedge clk or posedge globalReset) begin
      if (globalReset) begin
         issueValid <= 1'b0;
         issueOp    <= '0;
         issueRob   <= '0;
         issueOp1   <= '0;
         issueOp2   <= '0;
      end else if (flush) begin
         issueValid <= 1'b0;
      end else if (fuAvailable) begin
         issueValid <= any_ready;
         issueOp    <= winner.op;
         issueRob   <= winner.rob;
         issueOp1   <= winner.val1;
         issueOp2   <= winner.val2;
      end
   end

endmodule

// File: tb/tb_alu_issue_scheduler.sv
// Bench for alu_issue_scheduler: directed scenarios then random traffic.
// Expected values come from an in-order op list (oldest first) updated once per clock edge.
module tb_alu_issue_scheduler;

   localparam int ENTRIES = 4;

   logic        clk = 1'b0;
   logic        globalReset;
   logic        clear;
   logic        validCommit;
   logic        dispValid;
   logic        dispReady;
   logic [3:0]  dispOp;
   logic [2:0]  dispRob;
   logic        dispRdy1;
   logic        dispRdy2;
   logic [2:0]  dispTag1;
   logic [2:0]  dispTag2;
   logic [31:0] dispVal1;
   logic [31:0] dispVal2;
   logic        fuAvailable;
   logic        issueValid;
   logic [3:0]  issueOp;
   logic [2:0]  issueRob;
   logic [31:0] issueOp1;
   logic [31:0] issueOp2;
   logic [2:0]  occupancy;

   commonDataBus #(.WIDTH(31), .ROB(2)) cdb ();

   alu_issue_scheduler #(
      .WIDTH   (31),
      .ROB     (2),
      .ALUOP   (3),
      .ENTRIES (ENTRIES)
   ) dut (
      .clk         (clk),
      .globalReset (globalReset),
      .clear       (clear),
      .validCommit (validCommit),
      .dataBus     (cdb),
      .dispValid   (dispValid),
      .dispReady   (dispReady),
      .dispOp      (dispOp),
      .dispRob     (dispRob),
      .dispRdy1    (dispRdy1),
      .dispRdy2    (dispRdy2),
      .dispTag1    (dispTag1),
      .dispTag2    (dispTag2),
      .dispVal1    (dispVal1),
      .dispVal2    (dispVal2),
      .fuAvailable (fuAvailable),
      .issueValid  (issueValid),
      .issueOp     (issueOp),
      .issueRob    (issueRob),
      .issueOp1    (issueOp1),
      .issueOp2    (issueOp2),
      .occupancy   (occupancy)
   );

   always #5 clk = ~clk;

   // Reference: ops waiting in dispatch order, oldest at the front
   typedef struct {
      logic [3:0]  op;
      logic [2:0]  rob;
      bit          r1;
      logic [2:0]  t1;
      logic [31:0] v1;
      bit          r2;
      logic [2:0]  t2;
      logic [31:0] v2;
   } mop_t;

   mop_t        q[$];
   logic        m_iv;
   logic [3:0]  m_op;
   logic [2:0]  m_rob;
   logic [31:0] m_o1;
   logic [31:0] m_o2;

   int total  = 0;
   int passed = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      total++;
      assert (got === want) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
   endtask

   task automatic model_reset();
      q.delete();
      m_iv  = 1'b0;
      m_op  = '0;
      m_rob = '0;
      m_o1  = '0;
      m_o2  = '0;
   endtask

   // Apply one clock edge to the reference using the inputs currently driven
   task automatic model_edge();
      int   w;
      bit   acc;
      mop_t n;
      w = -1;
      if (clear && validCommit) begin
         q.delete();
         m_iv = 1'b0;
      end else begin
         foreach (q[i]) if (w < 0 && q[i].r1 && q[i].r2) w = i;
         acc  = dispValid && (q.size() < ENTRIES);
         n.op = dispOp;   n.rob = dispRob;
         n.r1 = dispRdy1; n.t1 = dispTag1; n.v1 = dispVal1;
         n.r2 = dispRdy2; n.t2 = dispTag2; n.v2 = dispVal2;
         if (!n.r1 && cdb.validBroadcast && cdb.robEntry == n.t1) begin n.r1 = 1; n.v1 = cdb.result; end
         if (!n.r2 && cdb.validBroadcast && cdb.robEntry == n.t2) begin n.r2 = 1; n.v2 = cdb.result; end
         if (fuAvailable) begin
            m_iv = (w >= 0);
            if (w >= 0) begin
               m_op = q[w].op; m_rob = q[w].rob; m_o1 = q[w].v1; m_o2 = q[w].v2;
            end else begin
               m_op = '0; m_rob = '0; m_o1 = '0; m_o2 = '0;
            end
         end
         if (cdb.validBroadcast) begin
            foreach (q[i]) begin
               if (!q[i].r1 && q[i].t1 == cdb.robEntry) begin q[i].r1 = 1; q[i].v1 = cdb.result; end
               if (!q[i].r2 && q[i].t2 == cdb.robEntry) begin q[i].r2 = 1; q[i].v2 = cdb.result; end
            end
         end
         if (fuAvailable && w >= 0) q.delete(w);
         if (acc) q.push_back(n);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, "_issueValid"}, issueValid, m_iv);
      chk({tag, "_issueOp"},    issueOp,    m_op);
      chk({tag, "_issueRob"},   issueRob,   m_rob);
      chk({tag, "_issueOp1"},   issueOp1,   m_o1);
      chk({tag, "_issueOp2"},   issueOp2,   m_o2);
      chk({tag, "_occupancy"},  occupancy,  q.size());
      chk({tag, "_dispReady"},  dispReady,  (q.size() < ENTRIES));
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
   endtask

   task automatic set_disp(input logic [3:0] op, input logic [2:0] rob,
                           input logic r1, input logic [2:0] t1, input logic [31:0] v1,
                           input logic r2, input logic [2:0] t2, input logic [31:0] v2);
      dispValid = 1'b1; dispOp = op; dispRob = rob;
      dispRdy1 = r1; dispTag1 = t1; dispVal1 = v1;
      dispRdy2 = r2; dispTag2 = t2; dispVal2 = v2;
   endtask

   task automatic no_disp();
      dispValid = 1'b0;
   endtask

   task automatic set_bc(input logic v, input logic [2:0] tag, input logic [31:0] res);
      cdb.validBroadcast = v; cdb.robEntry = tag; cdb.result = res;
   endtask

   initial begin
      globalReset = 1'b1; clear = 1'b0; validCommit = 1'b0; fuAvailable = 1'b0;
      set_disp(4'h0, 3'd0, 1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0);
      no_disp();
      set_bc(1'b0, 3'd0, 32'd0);
      model_reset();
      #1;
      chk("por_issueValid", issueValid, 1'b0);
      chk("por_occupancy",  occupancy,  3'd0);
      chk("por_dispReady",  dispReady,  1'b1);
      @(posedge clk); #1;
      globalReset = 1'b0;

      // 1: reset asynchronously with three slots valid and a dispatch in flight
      for (int i = 0; i < 3; i++) begin
         set_disp(4'h1, 3'(i), 1'b0, 3'd7, 32'd0, 1'b1, 3'd0, 32'd9);
         step("t1_fill");
      end
      set_disp(4'h2, 3'd4, 1'b1, 3'd0, 32'd1, 1'b1, 3'd0, 32'd2);
      globalReset = 1'b1;
      #1;
      chk("t1_issueValid", issueValid, 1'b0);
      chk("t1_occupancy",  occupancy,  3'd0);
      chk("t1_dispReady",  dispReady,  1'b1);
      model_reset();
      no_disp();
      @(posedge clk); #1;
      globalReset = 1'b0;

      // 2: both operands ready at dispatch -> issue on the next edge
      fuAvailable = 1'b1;
      set_disp(4'h0, 3'd3, 1'b1, 3'd0, 32'd5, 1'b1, 3'd0, 32'd7);
      step("t2_disp");
      no_disp();
      step("t2_issue");
      chk("t2_issueValid", issueValid, 1'b1);
      chk("t2_issueRob",   issueRob,   3'd3);
      chk("t2_issueOp1",   issueOp1,   32'd5);
      chk("t2_issueOp2",   issueOp2,   32'd7);
      chk("t2_occupancy",  occupancy,  3'd0);

      // 3: wakeup two cycles after dispatch, then same-cycle bypass
      set_disp(4'h2, 3'd1, 1'b1, 3'd0, 32'd11, 1'b0, 3'd4, 32'd0);
      step("t3_disp");
      no_disp();
      step("t3_wait");
      set_bc(1'b1, 3'd4, 32'hDEAD);
      step("t3_bcast");
      chk("t3_not_yet", issueValid, 1'b0);
      set_bc(1'b0, 3'd0, 32'd0);
      step("t3_issue");
      chk("t3_issueRob", issueRob, 3'd1);
      chk("t3_issueOp2", issueOp2, 32'hDEAD);
      set_disp(4'h3, 3'd1, 1'b1, 3'd0, 32'd12, 1'b0, 3'd4, 32'd0);
      set_bc(1'b1, 3'd4, 32'hBEEF);
      step("t3b_disp");
      no_disp();
      set_bc(1'b0, 3'd0, 32'd0);
      step("t3b_issue");
      chk("t3b_issueValid", issueValid, 1'b1);
      chk("t3b_issueOp2",   issueOp2,   32'hBEEF);

      // 4: fill all slots, fifth dispatch ignored, one issue reopens a slot
      for (int i = 0; i < 4; i++) begin
         set_disp(4'(i + 4), 3'(i), 1'b1, 3'd0, 32'(i), 1'b0, 3'(i + 4), 32'd0);
         step("t4_fill");
      end
      chk("t4_full_occ",   occupancy, 3'd4);
      chk("t4_full_ready", dispReady, 1'b0);
      set_disp(4'hF, 3'd7, 1'b1, 3'd0, 32'd1, 1'b1, 3'd0, 32'd1);
      step("t4_fifth");
      chk("t4_fifth_occ", occupancy, 3'd4);
      no_disp();
      set_bc(1'b1, 3'd6, 32'h66);
      step("t4_wake");
      chk("t4_wake_ready", dispReady, 1'b0);
      set_bc(1'b0, 3'd0, 32'd0);
      step("t4_issue");
      chk("t4_issueRob",   issueRob,  3'd2);
      chk("t4_reopen",     dispReady, 1'b1);
      set_bc(1'b1, 3'd4, 32'h44); step("t4_drain");
      set_bc(1'b1, 3'd5, 32'h55); step("t4_drain");
      set_bc(1'b1, 3'd7, 32'h77); step("t4_drain");
      set_bc(1'b0, 3'd0, 32'd0);
      for (int i = 0; i < 3; i++) step("t4_drain");
      chk("t4_empty", occupancy, 3'd0);

      // 5: two ops woken together while the ALU is busy; older issues first
      set_disp(4'h1, 3'd2, 1'b1, 3'd0, 32'd20, 1'b0, 3'd6, 32'd0);
      step("t5_disp_a");
      set_disp(4'h2, 3'd5, 1'b1, 3'd0, 32'd50, 1'b0, 3'd6, 32'd0);
      step("t5_disp_b");
      no_disp();
      fuAvailable = 1'b0;
      set_bc(1'b1, 3'd6, 32'h600D);
      step("t5_hold0");
      set_bc(1'b0, 3'd0, 32'd0);
      step("t5_hold1");
      chk("t5_hold_occ", occupancy, 3'd2);
      fuAvailable = 1'b1;
      step("t5_first");
      chk("t5_first_rob", issueRob, 3'd2);
      step("t5_second");
      chk("t5_second_rob", issueRob, 3'd5);
      chk("t5_second_op2", issueOp2, 32'h600D);

      // 6: qualified flush drops everything including the same-cycle dispatch
      fuAvailable = 1'b0;
      for (int i = 0; i < 3; i++) begin
         set_disp(4'h9, 3'(i), 1'b0, 3'd3, 32'd0, 1'b1, 3'd0, 32'd1);
         step("t6_fill");
      end
      set_disp(4'hA, 3'd6, 1'b1, 3'd0, 32'd3, 1'b1, 3'd0, 32'd4);
      clear = 1'b1; validCommit = 1'b1;
      step("t6_flush");
      chk("t6_flush_occ", occupancy,  3'd0);
      chk("t6_flush_iv",  issueValid, 1'b0);
      no_disp();
      clear = 1'b0; validCommit = 1'b0; fuAvailable = 1'b1;
      step("t6_after");
      step("t6_after");
      chk("t6_absent", issueValid, 1'b0);
      set_disp(4'hB, 3'd6, 1'b1, 3'd0, 32'd8, 1'b1, 3'd0, 32'd9);
      clear = 1'b1; validCommit = 1'b0;
      step("t6_unqual");
      chk("t6_unqual_occ", occupancy, 3'd1);
      no_disp();
      clear = 1'b0;
      step("t6_unqual_issue");
      chk("t6_unqual_rob", issueRob, 3'd6);

      // Random traffic against the reference
      for (int c = 0; c < 500; c++) begin
         dispValid   = ($urandom_range(0, 99) < 60);
         dispOp      = 4'($urandom);
         dispRob     = 3'($urandom);
         dispRdy1    = 1'($urandom_range(0, 1));
         dispRdy2    = 1'($urandom_range(0, 1));
         dispTag1    = 3'($urandom);
         dispTag2    = 3'($urandom);
         dispVal1    = $urandom;
         dispVal2    = $urandom;
         set_bc(1'($urandom_range(0, 1)), 3'($urandom), $urandom);
         fuAvailable = ($urandom_range(0, 99) < 70);
         clear       = ($urandom_range(0, 99) < 5);
         validCommit = ($urandom_range(0, 99) < 50);
         step("rnd");
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
